seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
- Serial pattern transmitter: emits a programmable PAT_W-bit pattern MSB-first, one bit per clock, repeated a programmed number of times.
- Supports overlapping and non-overlapping framing, with optional idle gap bits between instances.
- Drives the stimulus side of the serial sequence-detector blocks, e.g. generating 1001 streams for the Mealy detectors. Fully synchronous apart from reset.

Parameters:
PAT_W, 4, pattern length in bits (2..16)
CNT_W, 8, width of repeat counter
GAP_W, 4, width of inter-instance gap length

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request; sampled only in IDLE
abort  in  1  stop transmission; highest priority after rst
pattern  in  PAT_W  pattern to send, bit PAT_W-1 sent first
repeat_cnt  in  CNT_W  number of instances; 0 = continuous until abort
gap_len  in  GAP_W  idle 0-bits between instances (non-overlap mode only)
overlap_mode  in  1  1 = successive instances share boundary bit when legal
bit_out  out  1  serial data, registered
bit_valid  out  1  bit_out carries a pattern bit this cycle (0 during gap/idle)
last_bit  out  1  pulse with final bit of each instance
busy  out  1  high from cycle after accepted start until return to IDLE
done  out  1  1-cycle pulse the cycle after final bit of final instance

Behaviour:
- Reset (async, rst=1): state IDLE, bit_out=0, bit_valid=0, last_bit=0, busy=0, done=0, all counters 0.
- All outputs registered; no combinational input-to-output path.
- States: IDLE, SEND, GAP, FIN.
- IDLE: on start=1, latch pattern, repeat_cnt, gap_len, overlap_mode into shadow registers; go to SEND. Inputs after acceptance are ignored until IDLE again. start while busy is ignored.
- Latency: first bit (pattern MSB) appears on bit_out with bit_valid=1 on the cycle after start is sampled. busy rises the same cycle.
- SEND: one bit per cycle, MSB first, via a bit index counter.
  - On the last bit of an instance: last_bit=1.
  - If instances remain (or continuous mode): go to GAP when overlap_mode=0 and gap_len>0, otherwise stay in SEND for the next instance.
  - When no instances remain: go to FIN.
- Overlap rule: effective only when overlap_mode=1 and pattern[PAT_W-1]==pattern[0]. Instances 2..N then skip their first bit, so each instance is PAT_W-1 bits long.
  - Example: 1001 x3 -> 1001001001 (10 bits).
  - If the MSB/LSB condition fails, overlap_mode behaves as 0 with no gap.
  - gap_len is ignored in overlap mode.
- GAP: bit_out=0, bit_valid=0 for exactly gap_len cycles, then SEND.
- FIN: bit_valid=0, busy=0, done=1 for one cycle; then IDLE. A new start is accepted in IDLE the following cycle.
- Repeat counting:
  - Instance counter decrements on each last_bit.
  - repeat_cnt=1 sends exactly one instance.
  - repeat_cnt=2^CNT_W-1 sends the maximum count with no wrap.
  - repeat_cnt=0 never decrements and never raises done.
- abort=1 in any non-IDLE state: the next cycle is IDLE with bit_valid=0, busy=0, last_bit=0, done=0; the partial instance is discarded. abort in IDLE has no effect and wins over a simultaneous start.
- rst mid-transmission: immediate return to reset values; no done pulse.
- Between bits, bit_out holds 0 whenever bit_valid=0.

Optional Feature:
SEQ_GEN_ERR_INJ_EN
- Defined: adds input err_inject (1 bit). When err_inject=1 in a cycle whose output bit will be valid, that transmitted bit is inverted. The pattern register is unaffected, and it has no effect in GAP, IDLE or FIN. Used to prove detector rejection.
- Not defined: port absent; logic identical to the feature with err_inject tied 0.

Test Plan:
- Reset mid-SEND (pattern=1001, repeat_cnt=3, assert rst after 2 bits) -> outputs go to 0 immediately; no done; later start runs cleanly from the MSB.
- pattern=1001, repeat_cnt=2, overlap_mode=0, gap_len=0 -> valid bits 10011001, last_bit at bits 4 and 8, done one cycle after bit 8, busy high 8 cycles.
- pattern=1001, repeat_cnt=3, overlap_mode=1 -> 1001001001 contiguous (10 valid cycles), last_bit at bits 4, 7, 10.
- pattern=1011, repeat_cnt=2, overlap_mode=1 (MSB!=LSB), gap_len=5 -> 10111011 with no gap and no overlap.
- pattern=1001, repeat_cnt=2, overlap_mode=0, gap_len=3 -> 1001, 3 cycles bit_valid=0/bit_out=0, 1001, done.
- repeat_cnt=0, then abort after 9 bits -> continuous 100110011; IDLE next cycle, no done. A start pulsed during busy is ignored. With SEQ_GEN_ERR_INJ_EN, err_inject on bit 2 -> 1101.

Source files
------------

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: control/serial bundle for seq_pattern_gen; err_inject exists only with SEQ_GEN_ERR_INJ_EN
interface seq_pattern_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             overlap_mode;
  logic             bit_out;
  logic             bit_valid;
  logic             last_bit;
  logic             busy;
  logic             done;
`ifdef SEQ_GEN_ERR_INJ_EN
  logic             err_inject;
`endif

  modport master (
`ifdef SEQ_GEN_ERR_INJ_EN
    output err_inject,
`endif
    output start, abort, pattern, repeat_cnt, gap_len, overlap_mode,
    input  bit_out, bit_valid, last_bit, busy, done
  );

  modport slave (
`ifdef SEQ_GEN_ERR_INJ_EN
    input  err_inject,
`endif
    input  start, abort, pattern, repeat_cnt, gap_len, overlap_mode,
    output bit_out, bit_valid, last_bit, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern transmitter with repeat, gap and overlap framing.
// Optional SEQ_GEN_ERR_INJ_EN adds err_inject to invert the next transmitted bit.
module seq_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_pattern_gen_if.slave io
);
  localparam int IDX_W = $clog2(PAT_W);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d, gap_q, gap_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic             bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
  logic             last_bit_q, last_bit_d, busy_q, busy_d, done_q, done_d;
  logic             emit, err, more, ovl_eff;

`ifdef SEQ_GEN_ERR_INJ_EN
  assign err = io.err_inject;
`else
  assign err = 1'b0;
`endif

  // overlap only holds when the boundary bit is shared; rem_q==0 means continuous
  assign ovl_eff = ovl_q && (pat_q[PAT_W-1] == pat_q[0]);
  assign more    = rem_q != CNT_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    gcnt_d  = gcnt_q;
    gap_d   = gap_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    emit    = 1'b0;
    if (state_q != IDLE && io.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (io.start && !io.abort) begin
          state_d = SEND;
          pat_d   = io.pattern;
          rem_d   = io.repeat_cnt;
          gap_d   = io.gap_len;
          ovl_d   = io.overlap_mode;
          idx_d   = IDX_W'(PAT_W - 1);
          emit    = 1'b1;
        end
        SEND: begin
          if (idx_q != '0) begin
            idx_d = idx_q - IDX_W'(1);
            emit  = 1'b1;
          end else if (!more) begin
            state_d = FIN;
          end else begin
            rem_d = (rem_q == '0) ? rem_q : rem_q - CNT_W'(1);
            if (ovl_eff) begin
              idx_d = IDX_W'(PAT_W - 2);
              emit  = 1'b1;
            end else if (!ovl_q && gap_q != '0) begin
              state_d = GAP;
              gcnt_d  = gap_q - GAP_W'(1);
            end else begin
              idx_d = IDX_W'(PAT_W - 1);
              emit  = 1'b1;
            end
          end
        end
        GAP: if (gcnt_q == '0) begin
          state_d = SEND;
          idx_d   = IDX_W'(PAT_W - 1);
          emit    = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
    bit_valid_d = emit;
    bit_out_d   = emit && (pat_d[idx_d] ^ err);
    last_bit_d  = emit && (idx_d == '0);
    busy_d      = (state_d == SEND) || (state_d == GAP);
    done_d      = state_d == FIN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      gcnt_q      <= '0;
      gap_q       <= '0;
      pat_q       <= '0;
      ovl_q       <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      gcnt_q      <= gcnt_d;
      gap_q       <= gap_d;
      pat_q       <= pat_d;
      ovl_q       <= ovl_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign io.bit_out   = bit_out_q;
  assign io.bit_valid = bit_valid_q;
  assign io.last_bit  = last_bit_q;
  assign io.busy      = busy_q;
  assign io.done      = done_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed scoreboard bench; expected {valid,bit,last} stream queued per run.
module tb_seq_pattern_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [2:0] exp_q[$];

  seq_pattern_gen_if #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) bus ();

  seq_pattern_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic dn);
    chk({tag, " valid"}, 16'(bus.bit_valid), 16'd0);
    chk({tag, " bit"},   16'(bus.bit_out),   16'd0);
    chk({tag, " last"},  16'(bus.last_bit),  16'd0);
    chk({tag, " busy"},  16'(bus.busy),      16'd0);
    chk({tag, " done"},  16'(bus.done),      16'(dn));
  endtask

  // reference stream: instances, optional zero gaps, overlap skips the first bit of instances 2..N
  task automatic build(input logic [3:0] p, input int n, input int g, input bit ov, input int limit);
    bit eff = ov && (p[3] == p[0]);
    int nb = 0;
    for (int i = 0; (n == 0) ? (nb < limit) : (i < n); i++) begin
      if (i > 0 && !ov && g > 0)
        for (int k = 0; k < g; k++) exp_q.push_back(3'b000);
      for (int b = (i > 0 && eff) ? 2 : 3; b >= 0; b--) begin
        if (n == 0 && nb == limit) break;
        exp_q.push_back({1'b1, p[b], b == 0});
        nb++;
      end
    end
  endtask

  task automatic run(input string tag, input logic [3:0] p, input int n, input int g, input bit ov,
                     input int limit, input int err_pos, input bit abort_end, input int stray);
    int c = 0;
    int cyc = 0;
    logic [2:0] e;
    build(p, n, g, ov, limit);
    if (err_pos >= 0) exp_q[err_pos] = exp_q[err_pos] ^ 3'b010;
    bus.pattern      = p;
    bus.repeat_cnt   = 8'(n);
    bus.gap_len      = 4'(g);
    bus.overlap_mode = ov;
    bus.start        = 1'b1;
`ifdef SEQ_GEN_ERR_INJ_EN
    bus.err_inject   = (err_pos == 0);
`endif
    @(negedge clk);
    bus.start        = 1'b0;
    bus.pattern      = ~p;
    bus.repeat_cnt   = 8'd1;
    bus.gap_len      = 4'd7;
    bus.overlap_mode = ~ov;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " stream"}, 16'({bus.bit_valid, bus.bit_out, bus.last_bit}), 16'(e));
      chk({tag, " busy"}, 16'(bus.busy), 16'd1);
      if (e[2]) c++;
`ifdef SEQ_GEN_ERR_INJ_EN
      bus.err_inject = (c == err_pos);
`endif
      bus.start = (cyc == stray);
      cyc++;
      if (exp_q.size() == 0 && abort_end) bus.abort = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
`ifdef SEQ_GEN_ERR_INJ_EN
    bus.err_inject = 1'b0;
`endif
    if (abort_end) begin
      bus.abort = 1'b0;
      chk_quiet({tag, " abort"}, 1'b0);
      @(negedge clk);
      chk_quiet({tag, " post"}, 1'b0);
    end else begin
      chk_quiet({tag, " fin"}, 1'b1);
      @(negedge clk);
      chk_quiet({tag, " idle"}, 1'b0);
    end
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.pattern      = 4'h0;
    bus.repeat_cnt   = 8'd0;
    bus.gap_len      = 4'd0;
    bus.overlap_mode = 1'b0;
`ifdef SEQ_GEN_ERR_INJ_EN
    bus.err_inject   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk_quiet("reset", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    // reset mid-send
    bus.pattern    = 4'b1001;
    bus.repeat_cnt = 8'd3;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rst_b0", 16'({bus.bit_valid, bus.bit_out}), 16'b11);
    @(negedge clk);
    chk("rst_b1", 16'({bus.bit_valid, bus.bit_out}), 16'b10);
    rst = 1'b1;
    #1;
    chk_quiet("rst_async", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_quiet("rst_after", 1'b0);
    end
    run("clean",   4'b1001, 1,   0, 1'b0, 0, -1, 1'b0, -1);
    run("nov2",    4'b1001, 2,   0, 1'b0, 0, -1, 1'b0, -1);
    run("ovl3",    4'b1001, 3,   0, 1'b1, 0, -1, 1'b0, -1);
    run("ovlbad",  4'b1011, 2,   5, 1'b1, 0, -1, 1'b0, -1);
    run("gap3",    4'b1001, 2,   3, 1'b0, 0, -1, 1'b0, -1);
    run("cont",    4'b1001, 0,   0, 1'b0, 9, -1, 1'b1, 3);
    run("max",     4'b1001, 255, 0, 1'b1, 0, -1, 1'b0, -1);
    run("one0110", 4'b0110, 1,   2, 1'b0, 0, -1, 1'b0, -1);
`ifdef SEQ_GEN_ERR_INJ_EN
    run("errinj",  4'b1001, 1,   0, 1'b0, 0, 1, 1'b0, -1);
`endif
    // abort wins over start in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk_quiet("idle_abort", 1'b0);
    @(negedge clk);
    chk_quiet("idle_abort2", 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
